rvm_ifetch: RTL and testbench

Instruction fetch stage for the RISC-V multi-cycle core. It holds the fetch PC and issues one word-aligned read at a time on the instruction memory port. It buffers the returned word and presents it, with its PC, to the decode/execute control that drives the add, bitwise and shift functional units. Control flow changes (branches, jumps, traps) enter through a redirect input.

---
 rtl/rvm_ifetch.sv | 91 +++++++++
 tb/tb_rvm_ifetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rvm_ifetch.sv
// rvm_ifetch: instruction fetch stage, one outstanding word read at a time, with redirect.
// Ports:
//   clk, resetn                   clock and asynchronous active-low reset
//   imem_req/addr/gnt             request channel (transfer on req && gnt)
//   imem_rvalid/rdata             response channel (one response per grant)
//   instr_valid/ready/data/pc     fetched instruction handed to decode
//   redirect, redirect_pc         restart fetch at a new (word-aligned) address
module rvm_ifetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_data,
   output logic [31:0] instr_pc,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);
   typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_t;
   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        discard_q, discard_d;
   logic [31:0] instr_data_q, instr_data_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_BOOT;
         fetch_pc_q   <= RESET_PC;
         discard_q    <= 1'b0;
         instr_data_q <= '0;
         instr_pc_q   <= '0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         discard_q    <= discard_d;
         instr_data_q <= instr_data_d;
         instr_pc_q   <= instr_pc_d;
      end
   end
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      discard_d    = discard_q;
      instr_data_d = instr_data_q;
      instr_pc_d   = instr_pc_q;
      case (state_q)
         S_BOOT: state_d = S_REQ;
         S_REQ: begin
            // a redirect racing the grant leaves a stale response to swallow
            if (imem_gnt) begin
               state_d   = S_WAIT;
               discard_d = redirect;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               discard_d = 1'b0;
               if (discard_q || redirect) begin
                  state_d = S_REQ;
               end else begin
                  state_d      = S_HOLD;
                  instr_data_d = imem_rdata;
                  instr_pc_d   = fetch_pc_q;
               end
            end else if (redirect) begin
               discard_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect || instr_ready) begin
               state_d    = S_REQ;
               fetch_pc_d = fetch_pc_q + 32'd4;
            end
         end
         default: state_d = S_BOOT;
      endcase
      // redirect target overrides the sequential +4 in every state
      if (redirect) fetch_pc_d = redirect_pc & ~32'd3;
   end
   assign imem_req    = (state_q == S_REQ);
   assign imem_addr   = fetch_pc_q;
   assign instr_valid = (state_q == S_HOLD);
   assign instr_data  = instr_data_q;
   assign instr_pc    = instr_pc_q;
endmodule

// File: tb/tb_rvm_ifetch.sv
// tb_rvm_ifetch: scoreboard bench for rvm_ifetch with a directed memory responder.
module tb_rvm_ifetch;
   logic        clk = 1'b0;
   logic        resetn;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        redirect;
   logic [31:0] redirect_pc;
   int checks = 0;
   int errors = 0;
   logic [31:0] exp_addr[$];
   logic [63:0] exp_instr[$];
   logic        gnt_en;
   int          rlat;
   int          lat_cnt = 0;
   logic [31:0] pend_addr = '0;
   rvm_ifetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .resetn(resetn),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_data(instr_data), .instr_pc(instr_pc),
      .redirect(redirect), .redirect_pc(redirect_pc)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], 16'h0013};
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic drain;
      int n = 0;
      while ((exp_addr.size() != 0 || exp_instr.size() != 0) && n < 80) begin
         tick();
         n++;
      end
      if (n >= 80) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d addr / %0d instr pending expected 0", exp_addr.size(), exp_instr.size());
         exp_addr.delete();
         exp_instr.delete();
      end
      gnt_en = 1'b0;
   endtask
   // memory responder: decides grants after the edge, checks granted addresses
   initial begin
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         imem_gnt = 1'b0;
         imem_rvalid = 1'b0;
         if (!resetn) begin
            lat_cnt = 0;
         end else begin
            if (lat_cnt != 0) begin
               lat_cnt--;
               if (lat_cnt == 0) begin
                  imem_rvalid = 1'b1;
                  imem_rdata = mem_word(pend_addr);
               end
            end
            if (imem_req && gnt_en && lat_cnt == 0 && !imem_rvalid) begin
               imem_gnt = 1'b1;
               pend_addr = imem_addr;
               lat_cnt = rlat;
               if (exp_addr.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_grant: got addr %h expected no request", imem_addr);
               end else begin
                  chk("req_addr", imem_addr, exp_addr.pop_front());
               end
            end
         end
      end
   end
   // instruction monitor: every handshake must match the next expected {pc,data}
   initial begin
      forever begin
         @(negedge clk);
         if (resetn && instr_valid && instr_ready) begin
            if (exp_instr.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_instr: got pc %h data %h expected none", instr_pc, instr_data);
            end else begin
               logic [63:0] e;
               e = exp_instr.pop_front();
               chk("instr_pc", instr_pc, e[63:32]);
               chk("instr_data", instr_data, e[31:0]);
            end
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
   initial begin
      resetn = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
      gnt_en = 1'b1; rlat = 1;
      #2 resetn = 1'b0;
      #1;
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_data", instr_data, 32'h0);
      chk("rst_pc", instr_pc, 32'h0);
      // reset release, first fetch, back-pressure
      exp_addr.push_back(32'h0);
      exp_addr.push_back(32'h4);
      exp_instr.push_back({32'h0, 32'h0000_0013});
      exp_instr.push_back({32'h4, 32'h0004_0013});
      tick(); tick();
      resetn = 1'b1;
      instr_ready = 1'b0;
      chk("boot_req", {31'd0, imem_req}, 32'd0);
      tick();
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h0);
      tick();
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      chk("wait_req", {31'd0, imem_req}, 32'd0);
      tick();
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_data", instr_data, 32'h0000_0013);
      chk("hold_pc", instr_pc, 32'h0);
      repeat (5) begin
         tick();
         chk("bp_valid", {31'd0, instr_valid}, 32'd1);
         chk("bp_data", instr_data, 32'h0000_0013);
         chk("bp_pc", instr_pc, 32'h0);
         chk("bp_req", {31'd0, imem_req}, 32'd0);
      end
      instr_ready = 1'b1;
      tick();
      chk("next_req", {31'd0, imem_req}, 32'd1);
      chk("next_addr", imem_addr, 32'h4);
      drain();
      // redirect while waiting; late response must be dropped
      exp_addr.push_back(32'h8);
      exp_addr.push_back(32'h100);
      exp_instr.push_back({32'h100, 32'h0100_0013});
      rlat = 4;
      gnt_en = 1'b1;
      tick();
      chk("rw_req", {31'd0, imem_req}, 32'd0);
      redirect = 1'b1;
      redirect_pc = 32'h0000_0100;
      tick();
      redirect = 1'b0;
      rlat = 1;
      chk("rw_valid0", {31'd0, instr_valid}, 32'd0);
      tick();
      chk("rw_valid1", {31'd0, instr_valid}, 32'd0);
      tick();
      chk("rw_valid2", {31'd0, instr_valid}, 32'd0);
      tick();
      chk("rw_valid3", {31'd0, instr_valid}, 32'd0);
      chk("rw_req2", {31'd0, imem_req}, 32'd1);
      chk("rw_addr", imem_addr, 32'h100);
      drain();
      // redirect coincident with grant
      exp_addr.push_back(32'h104);
      exp_addr.push_back(32'h200);
      exp_instr.push_back({32'h200, 32'h0200_0013});
      redirect = 1'b1;
      redirect_pc = 32'h0000_0203;
      gnt_en = 1'b1;
      tick();
      redirect = 1'b0;
      chk("rg_req", {31'd0, imem_req}, 32'd0);
      tick();
      chk("rg_req2", {31'd0, imem_req}, 32'd1);
      chk("rg_addr", imem_addr, 32'h200);
      chk("rg_valid", {31'd0, instr_valid}, 32'd0);
      drain();
      // redirect in REQ without grant, then redirect + ready together in HOLD
      redirect = 1'b1;
      redirect_pc = 32'h0000_0040;
      tick();
      redirect = 1'b0;
      chk("rq_req", {31'd0, imem_req}, 32'd1);
      chk("rq_addr", imem_addr, 32'h40);
      exp_addr.push_back(32'h40);
      exp_addr.push_back(32'h80);
      exp_instr.push_back({32'h40, 32'h0040_0013});
      exp_instr.push_back({32'h80, 32'h0080_0013});
      instr_ready = 1'b0;
      gnt_en = 1'b1;
      tick();
      tick();
      chk("rh_valid", {31'd0, instr_valid}, 32'd1);
      chk("rh_pc", instr_pc, 32'h40);
      instr_ready = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h0000_0080;
      tick();
      redirect = 1'b0;
      chk("rh_req", {31'd0, imem_req}, 32'd1);
      chk("rh_addr", imem_addr, 32'h80);
      drain();
      // wrap past the top of memory, then reset while waiting
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
      exp_addr.push_back(32'hFFFF_FFFC);
      exp_addr.push_back(32'h0);
      exp_instr.push_back({32'hFFFF_FFFC, 32'hFFFC_0013});
      rlat = 6;
      gnt_en = 1'b1;
      drain();
      chk("pre_rst_data", instr_data, 32'hFFFC_0013);
      resetn = 1'b0;
      #1;
      chk("arst_req", {31'd0, imem_req}, 32'd0);
      chk("arst_addr", imem_addr, 32'h0);
      chk("arst_valid", {31'd0, instr_valid}, 32'd0);
      chk("arst_data", instr_data, 32'h0);
      chk("arst_pc", instr_pc, 32'h0);
      tick();
      resetn = 1'b1;
      rlat = 1;
      exp_addr.push_back(32'h0);
      exp_instr.push_back({32'h0, 32'h0000_0013});
      gnt_en = 1'b1;
      tick();
      chk("refetch_req", {31'd0, imem_req}, 32'd1);
      chk("refetch_addr", imem_addr, 32'h0);
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
